// File: rtl/switch_pkg.sv
// Shared constants and types for the 4-port packet switch.
// Packet layout: {data[17:10], type[9:8], target[7:4], source[3:0]}.
package switch_pkg;

   localparam int DEPTH        = 8;
   localparam int PACKET_WIDTH = 18;
   localparam int PTR_W        = 3;

   localparam int SRC_LSB = 0;
   localparam int TGT_LSB = 4;
   localparam int TYP_LSB = 8;
   localparam int DAT_LSB = 10;

   typedef enum logic [1:0] {
      PKT_SINGLE = 2'b01,
      PKT_MULTI  = 2'b10,
      PKT_BCAST  = 2'b11
   } pkt_type_e;

   typedef enum logic {
      IDLE = 1'b0,
      ARB  = 1'b1
   } port_state_e;

endpackage

// File: rtl/sw_input_port.sv
// Input port: 8-deep FWFT packet FIFO plus the FSM that walks the head
// packet's target mask until every requested output has granted it.
module sw_input_port
   import switch_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid,
   input  logic [PACKET_WIDTH-1:0] pkt,
   input  logic [3:0]              grant,
   output logic [3:0]              req,
   output logic [PACKET_WIDTH-1:0] header
);

   logic [PACKET_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [PTR_W:0]          fifo_count;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    write_en;
   logic                    read_en_fifo;
   port_state_e             current_state;
   logic [3:0]              remaining;
   logic [3:0]              remaining_next;

   assign fifo_full  = (fifo_count == (PTR_W+1)'(DEPTH));
   assign fifo_empty = (fifo_count == '0);
   assign header     = mem[rd_ptr];

   // Full is the registered flag: a same-cycle pop does not make room.
   assign write_en = valid && (pkt[TGT_LSB +: 4] != '0) && !fifo_full;

   assign remaining_next = remaining & ~grant;
   assign read_en_fifo   = (current_state == ARB) && (remaining_next == '0);
   assign req            = (current_state == ARB) ? remaining : '0;

   always_ff @(posedge clk) begin
      if (write_en) mem[wr_ptr] <= pkt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (write_en)     wr_ptr <= wr_ptr + 1'b1;
         if (read_en_fifo) rd_ptr <= rd_ptr + 1'b1;
         if (write_en && !read_en_fifo)
            fifo_count <= fifo_count + 1'b1;
         else if (!write_en && read_en_fifo)
            fifo_count <= fifo_count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         current_state <= IDLE;
         remaining     <= '0;
      end else begin
         unique case (current_state)
            IDLE: begin
               if (!fifo_empty) begin
                  remaining     <= header[TGT_LSB +: 4];
                  current_state <= ARB;
               end
            end
            ARB: begin
               remaining <= remaining_next;
               if (read_en_fifo) current_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/switch_4port.sv
// 4-port switch core: four input ports, one round-robin arbiter per
// output, and a two-register output path (grant capture, then drive).
module switch_4port
   import switch_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      valid_in,
   input  logic [3:0][3:0] source_in,
   input  logic [3:0][3:0] target_in,
   input  logic [3:0][1:0] pkt_type_in,
   input  logic [3:0][7:0] data_in,
   output logic [3:0]      valid_out,
   output logic [3:0][3:0] source_out,
   output logic [3:0][3:0] target_out,
   output logic [3:0][1:0] pkt_type_out,
   output logic [3:0][7:0] data_out
);

   logic [PACKET_WIDTH-1:0] header [4];
   logic [3:0]              req [4];
   logic [3:0]              grant [4];
   logic [1:0]              rr_ptr [4];
   logic [1:0]              win_idx [4];
   logic [3:0]              win_found;
   logic [3:0]              stage_valid;
   logic [PACKET_WIDTH-1:0] stage_pkt [4];

   for (genvar p = 0; p < 4; p++) begin : g_port
      sw_input_port u_port (
         .clk    (clk),
         .rst_n  (rst_n),
         .valid  (valid_in[p]),
         .pkt    ({data_in[p], pkt_type_in[p],
                   target_in[p], source_in[p]}),
         .grant  (grant[p]),
         .req    (req[p]),
         .header (header[p])
      );
   end

   // Search starts at the pointer so the last winner goes to the back.
   always_comb begin
      logic [1:0] cand;
      for (int k = 0; k < 4; k++) begin
         win_found[k] = 1'b0;
         win_idx[k]   = rr_ptr[k];
         for (int off = 0; off < 4; off++) begin
            cand = rr_ptr[k] + 2'(off);
            if (!win_found[k] && req[cand][k]) begin
               win_found[k] = 1'b1;
               win_idx[k]   = cand;
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < 4; p++) begin
         grant[p] = '0;
         for (int k = 0; k < 4; k++)
            grant[p][k] = win_found[k] && (win_idx[k] == 2'(p));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_valid  <= '0;
         valid_out    <= '0;
         source_out   <= '0;
         target_out   <= '0;
         pkt_type_out <= '0;
         data_out     <= '0;
         for (int k = 0; k < 4; k++) begin
            rr_ptr[k]    <= '0;
            stage_pkt[k] <= '0;
         end
      end else begin
         stage_valid <= win_found;
         valid_out   <= stage_valid;
         for (int k = 0; k < 4; k++) begin
            if (win_found[k]) begin
               rr_ptr[k]    <= win_idx[k] + 2'd1;
               stage_pkt[k] <= header[win_idx[k]];
            end
            if (stage_valid[k]) begin
               source_out[k]   <= stage_pkt[k][SRC_LSB +: 4];
               target_out[k]   <= stage_pkt[k][TGT_LSB +: 4];
               pkt_type_out[k] <= stage_pkt[k][TYP_LSB +: 2];
               data_out[k]     <= stage_pkt[k][DAT_LSB +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_switch_4port.sv
// Bench for switch_4port: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_switch_4port;

   localparam int DEPTH_M = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [3:0]      valid_in;
   logic [3:0][3:0] source_in;
   logic [3:0][3:0] target_in;
   logic [3:0][1:0] pkt_type_in;
   logic [3:0][7:0] data_in;
   logic [3:0]      valid_out;
   logic [3:0][3:0] source_out;
   logic [3:0][3:0] target_out;
   logic [3:0][1:0] pkt_type_out;
   logic [3:0][7:0] data_out;

   switch_4port dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .valid_in     (valid_in),
      .source_in    (source_in),
      .target_in    (target_in),
      .pkt_type_in  (pkt_type_in),
      .data_in      (data_in),
      .valid_out    (valid_out),
      .source_out   (source_out),
      .target_out   (target_out),
      .pkt_type_out (pkt_type_out),
      .data_out     (data_out)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: per-port packet queues, a per-port set of outputs
   // still owed for the head packet, and per-output round-robin pointers.
   logic [17:0] mq [4][$];
   bit          m_busy [4];
   logic [3:0]  m_rem [4];
   int          m_ptr [4];
   bit          s1v [4];
   logic [17:0] s1p [4];
   bit          ev [4];
   logic [17:0] ep [4];
   int          acc [4];
   int          drops [4];
   int          peak [4];
   int          drop_bits;

   int          pulses [4];
   int          src_hits [4];
   logic [3:0]  last_src [4];
   int          total_pulses;
   logic [3:0]  ord3 [$];
   int          sent_bits;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int p = 0; p < 4; p++) begin
         mq[p].delete();
         m_busy[p] = 0;
         m_rem[p]  = '0;
         m_ptr[p]  = 0;
         s1v[p]    = 0;
         ev[p]     = 0;
         acc[p]    = 0;
         drops[p]  = 0;
         peak[p]   = 0;
      end
      drop_bits = 0;
   endtask

   task automatic model_step();
      int gp [4];
      bit full [4];
      for (int k = 0; k < 4; k++) begin
         gp[k] = -1;
         for (int o = 0; o < 4; o++) begin
            int p;
            p = (m_ptr[k] + o) % 4;
            if (gp[k] < 0 && m_busy[p] && m_rem[p][k]) gp[k] = p;
         end
      end
      for (int k = 0; k < 4; k++) begin
         ev[k] = s1v[k];
         ep[k] = s1p[k];
         s1v[k] = (gp[k] >= 0);
         if (gp[k] >= 0) begin
            s1p[k]   = mq[gp[k]][0];
            m_ptr[k] = (gp[k] + 1) % 4;
         end
      end
      for (int p = 0; p < 4; p++) begin
         full[p] = (mq[p].size() >= DEPTH_M);
         if (m_busy[p]) begin
            for (int k = 0; k < 4; k++)
               if (gp[k] == p) m_rem[p][k] = 1'b0;
            if (m_rem[p] == '0) begin
               void'(mq[p].pop_front());
               m_busy[p] = 0;
            end
         end else if (mq[p].size() > 0) begin
            m_busy[p] = 1;
            m_rem[p]  = mq[p][0][7:4];
         end
         if (valid_in[p] && target_in[p] != '0) begin
            if (full[p]) begin
               drops[p]++;
               drop_bits += $countones(target_in[p]);
            end else begin
               mq[p].push_back({data_in[p], pkt_type_in[p],
                                target_in[p], source_in[p]});
               acc[p]++;
            end
         end
         if (mq[p].size() > peak[p]) peak[p] = mq[p].size();
      end
   endtask

   function automatic bit model_idle();
      for (int p = 0; p < 4; p++)
         if (mq[p].size() != 0 || m_busy[p] || s1v[p] || ev[p]) return 0;
      return 1;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_clear();
         else model_step();
      end
   end

   // Compare process: every cycle, every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("valid_out[%0d]", k), 32'(valid_out[k]), 32'(ev[k]));
            if (ev[k] && valid_out[k])
               chk($sformatf("pkt_out[%0d]", k),
                   32'({data_out[k], pkt_type_out[k], target_out[k], source_out[k]}),
                   32'(ep[k]));
            if (valid_out[k]) begin
               pulses[k]++;
               total_pulses++;
               last_src[k] = source_out[k];
               for (int p = 0; p < 4; p++)
                  if (source_out[k] == 4'(1 << p)) src_hits[p]++;
               if (k == 3) ord3.push_back(source_out[3]);
            end
         end
      end
   end

   task automatic clear_obs();
      for (int k = 0; k < 4; k++) begin
         pulses[k]   = 0;
         src_hits[k] = 0;
         last_src[k] = '0;
      end
      total_pulses = 0;
      ord3.delete();
   endtask

   task automatic send(input int p, input logic [3:0] tgt,
                       input logic [1:0] ty, input logic [7:0] d);
      valid_in[p]    = 1'b1;
      source_in[p]   = 4'(1 << p);
      target_in[p]   = tgt;
      pkt_type_in[p] = ty;
      data_in[p]     = d;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      valid_in = '0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_obs();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (!model_idle() && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (n >= budget) begin
         n_fail++;
         $display("FAIL drain: still busy after %0d cycles, required idle", n);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      valid_in    = '0;
      source_in   = '0;
      target_in   = '0;
      pkt_type_in = '0;
      data_in     = '0;
      clear_obs();

      // 1: reset
      rst_n = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_valid", 32'(valid_out), 32'h0);
      chk("rst_data", 32'(data_out), 32'h0);
      chk("rst_source", 32'(source_out), 32'h0);
      chk("rst_target", 32'(target_out), 32'h0);
      chk("rst_type", 32'(pkt_type_out), 32'h0);

      // 2: single packet, p0 -> out2, visible after accept edge + 3
      send(0, 4'b0100, 2'b01, 8'hA5);
      @(negedge clk);
      valid_in = '0;
      @(negedge clk);
      chk("t2_early1", 32'(valid_out), 32'h0);
      @(negedge clk);
      chk("t2_early2", 32'(valid_out), 32'h0);
      @(negedge clk);
      chk("t2_valid", 32'(valid_out), 32'h4);
      chk("t2_source", 32'(source_out[2]), 32'h1);
      chk("t2_data", 32'(data_out[2]), 32'hA5);
      chk("t2_target", 32'(target_out[2]), 32'h4);
      chk("t2_type", 32'(pkt_type_out[2]), 32'h1);
      @(negedge clk);
      chk("t2_pulse_end", 32'(valid_out), 32'h0);
      drain(50);

      // 3: broadcast from p1
      clear_obs();
      send(1, 4'b1111, 2'b11, 8'h3C);
      @(negedge clk);
      valid_in = '0;
      drain(50);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t3_pulses%0d", k), 32'(pulses[k]), 32'd1);
         chk($sformatf("t3_src%0d", k), 32'(last_src[k]), 32'h2);
      end

      // 4: four-way contention on output 3, then pointer back at p0
      do_reset();
      for (int p = 0; p < 4; p++) send(p, 4'b1000, 2'b01, 8'(8'h40 + p));
      @(negedge clk);
      valid_in = '0;
      drain(50);
      chk("t4_count", 32'(ord3.size()), 32'd4);
      for (int i = 0; i < 4 && i < ord3.size(); i++)
         chk($sformatf("t4_order%0d", i), 32'(ord3[i]), 32'(1 << i));
      ord3.delete();
      send(3, 4'b1000, 2'b01, 8'h53);
      send(0, 4'b1000, 2'b01, 8'h50);
      @(negedge clk);
      valid_in = '0;
      drain(50);
      chk("t4_rr_count", 32'(ord3.size()), 32'd2);
      if (ord3.size() == 2) begin
         chk("t4_rr_first", 32'(ord3[0]), 32'h1);
         chk("t4_rr_second", 32'(ord3[1]), 32'h8);
      end

      // 5: overflow of p0 while all ports fight for output 3
      do_reset();
      for (int c = 0; c < 12; c++) begin
         send(0, 4'b1000, 2'b01, 8'(c));
         for (int p = 1; p < 4; p++) begin
            if (c < 8) send(p, 4'b1000, 2'b01, 8'(8'h80 + c));
            else valid_in[p] = 1'b0;
         end
         @(negedge clk);
      end
      valid_in = '0;
      drain(400);
      chk("t5_accepted", 32'(acc[0]), 32'd11);
      chk("t5_dropped", 32'(drops[0]), 32'd1);
      chk("t5_peak", 32'(peak[0]), 32'(DEPTH_M));
      chk("t5_delivered_p0", 32'(src_hits[0]), 32'd11);
      chk("t5_delivered_p1", 32'(src_hits[1]), 32'd8);

      // 6: random traffic, conservation of copies
      do_reset();
      sent_bits = 0;
      for (int c = 0; c < 20; c++) begin
         for (int p = 0; p < 4; p++) begin
            logic [1:0] ty;
            logic [3:0] tgt;
            ty = 2'($urandom_range(1, 3));
            if (ty == 2'b01) tgt = 4'(1 << $urandom_range(0, 3));
            else if (ty == 2'b10) tgt = 4'($urandom_range(0, 15));
            else tgt = 4'b1111;
            send(p, tgt, ty, 8'($urandom_range(0, 255)));
            sent_bits += $countones(tgt);
         end
         @(negedge clk);
      end
      valid_in = '0;
      drain(1000);
      chk("t6_conservation", 32'(total_pulses + drop_bits), 32'(sent_bits));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
